seq_detector_mealy: RTL and testbench

//  Parametrised Mealy serial-pattern detector; successor to the fixed-pattern lab FSM.

---
 rtl/seq_det_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/seq_detector_mealy.sv | 90 +++++++++
 tb/tb_seq_detector_mealy.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the Mealy serial-pattern detector.
// Provides the KMP next-state function used to build the transition table and
// the default state width. No ports; imported by seq_detector_mealy.
package seq_det_pkg;

   localparam int PAT_W_DEFAULT = 4;
   localparam int MAX_PAT_W     = 16;
   localparam int STATE_W       = $clog2(PAT_W_DEFAULT);

   // Longest pattern prefix (strictly shorter than pat_w) that is a suffix of
   // (first 'state' pattern bits followed by bit_in). Capping at pat_w-1 makes
   // the full-match case return failure(PAT_W), i.e. the overlap restart state.
   // Pattern bit pat_w-1 is the first bit received.
   function automatic int next_state(input logic [MAX_PAT_W-1:0] pattern,
                                     input int pat_w,
                                     input int state,
                                     input logic bit_in);
      int         len;
      int         res;
      int         j;
      logic       ok;
      logic       sb;
      logic [3:0] idx_s;
      logic [3:0] idx_p;
      len = state + 1;
      res = 0;
      for (int k = 1; k <= MAX_PAT_W; k++) begin
         if (k <= len && k < pat_w) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < k) begin
                  j     = len - k + i;
                  idx_s = 4'(pat_w - 1 - j);
                  idx_p = 4'(pat_w - 1 - i);
                  sb    = (j == state) ? bit_in : pattern[idx_s];
                  if (sb != pattern[idx_p]) ok = 1'b0;
               end
            end
            if (ok) res = k;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports: clock, rst (async active-low), inc, clr (sync, wins over inc), count.
// Latency: count reflects inc/clr one clock after they are sampled.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_mealy.sv
// Mealy detector for a PAT_W-bit serial pattern (MSB first) qualified by in_valid.
// Ports: clock, rst (async active-low), clear (sync), in_valid, in ->
//        match (combinational), match_q (match delayed 1 cycle), match_count (saturating), state.
// Config: define SEQDET_OVERLAP_EN to restart at failure(PAT_W) after a match; default restarts at 0.
module seq_detector_mealy
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic                     in,
   output logic                     match,
   output logic                     match_q,
   output logic [CNT_W-1:0]         match_count,
   output logic [$clog2(PAT_W)-1:0] state
);

   localparam int SW = $clog2(PAT_W);
   localparam int NS = 2 ** SW;

   // Transition table, one entry per state and input bit, built at elaboration.
   // Entries beyond PAT_W-1 are unreachable and tie to 0.
   logic [SW-1:0] tbl0 [NS];
   logic [SW-1:0] tbl1 [NS];

   for (genvar s = 0; s < NS; s++) begin : g_tbl
      localparam int N0 = (s < PAT_W) ? next_state(16'(PATTERN), PAT_W, s, 1'b0) : 0;
      localparam int N1 = (s < PAT_W) ? next_state(16'(PATTERN), PAT_W, s, 1'b1) : 0;
      assign tbl0[s] = SW'(N0);
      assign tbl1[s] = SW'(N1);
   end

   logic [SW-1:0] nxt;
   logic          hit;

   // Full pattern seen on this accepted bit (before clear/reset gating).
   assign hit = in_valid && (state == SW'(PAT_W - 1)) && (in == PATTERN[0]);

   // State register
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state <= '0;
      end else begin
         state <= nxt;
      end
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      if (clear) begin
         nxt = '0;
      end else if (in_valid) begin
         nxt = in ? tbl1[state] : tbl0[state];
`ifndef SEQDET_OVERLAP_EN
         if (hit) nxt = '0;
`endif
      end
   end

   // Mealy output: rst gating keeps match low while reset is held.
   always_comb begin
      match = 1'b0;
      if (rst && !clear && hit) match = 1'b1;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clock (clock),
      .rst   (rst),
      .inc   (match),
      .clr   (clear),
      .count (match_count)
   );

endmodule

// File: tb/tb_seq_detector_mealy.sv
// Directed bench for seq_detector_mealy: default pattern 1011, plus a CNT_W=2
// instance on the same inputs for the saturation case.
// Expected values are hand-computed; overlap-dependent ones follow SEQDET_OVERLAP_EN.
module tb_seq_detector_mealy;

   logic       clock = 1'b0;
   logic       rst;
   logic       clear;
   logic       in_valid;
   logic       in;
   logic       match, match_q;
   logic [7:0] match_count;
   logic [1:0] state;
   logic       match2, match_q2;
   logic [1:0] match_count2;
   logic [1:0] state2;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   seq_detector_mealy dut (
      .clock       (clock),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in          (in),
      .match       (match),
      .match_q     (match_q),
      .match_count (match_count),
      .state       (state)
   );

   seq_detector_mealy #(.CNT_W(2)) dut2 (
      .clock       (clock),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in          (in),
      .match       (match2),
      .match_q     (match_q2),
      .match_count (match_count2),
      .state       (state2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Apply inputs on the falling edge, settle 1 ns so match can be sampled.
   task automatic drive(input logic c, input logic v, input logic b);
      @(negedge clock);
      clear    = c;
      in_valid = v;
      in       = b;
      #1;
   endtask

   // Advance past the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [6:0] stream;
   logic [6:0] exp_m;
   logic [1:0] exp_st4;
   logic [7:0] exp_cnt3;
   logic [1:0] exp_st_after;

   initial begin
`ifdef SEQDET_OVERLAP_EN
      exp_m        = 7'b0001001;
      exp_st4      = 2'd1;
      exp_cnt3     = 8'd2;
      exp_st_after = 2'd1;
`else
      exp_m        = 7'b0001000;
      exp_st4      = 2'd0;
      exp_cnt3     = 8'd1;
      exp_st_after = 2'd0;
`endif
      stream   = 7'b1011011;
      rst      = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b1;
      in       = 1'b1;

      // 1: reset held while clock runs
      #20;
      chk("rst_match", match, 0);
      chk("rst_match_q", match_q, 0);
      chk("rst_count", match_count, 0);
      chk("rst_state", state, 0);
      drive(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      chk("rel_state", state, 0);
      chk("rel_count", match_count, 0);

      // 2: 1,0,1,1
      drive(1'b0, 1'b1, 1'b1); chk("t2_m1", match, 0); tick(); chk("t2_s1", state, 1);
      drive(1'b0, 1'b1, 1'b0); chk("t2_m2", match, 0); tick(); chk("t2_s2", state, 2);
      drive(1'b0, 1'b1, 1'b1); chk("t2_m3", match, 0); tick(); chk("t2_s3", state, 3);
      drive(1'b0, 1'b1, 1'b1); chk("t2_m4", match, 1); tick();
      chk("t2_match_q", match_q, 1);
      chk("t2_count", match_count, 1);
      chk("t2_state", state, exp_st_after);
      drive(1'b0, 1'b0, 1'b0); tick();
      chk("t2_match_q_drop", match_q, 0);

      // 3: 1011011
      drive(1'b1, 1'b0, 1'b0); tick();
      chk("t3_clr_count", match_count, 0);
      chk("t3_clr_state", state, 0);
      for (int i = 6; i >= 0; i--) begin
         drive(1'b0, 1'b1, stream[i]);
         chk($sformatf("t3_match_bit%0d", 7 - i), match, exp_m[i]);
         tick();
         if (i == 3) chk("t3_state_after_bit4", state, exp_st4);
      end
      chk("t3_count", match_count, exp_cnt3);

      // 4: 1,0,1, idle 5 cycles, then 1
      drive(1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1); tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1);
         chk("t4_idle_match", match, 0);
         tick();
         chk("t4_idle_state", state, 3);
      end
      chk("t4_idle_count", match_count, 0);
      drive(1'b0, 1'b1, 1'b1);
      chk("t4_match", match, 1);
      tick();
      chk("t4_count", match_count, 1);

      // 5: five back-to-back 1011 patterns; dut2 saturates at 3
      drive(1'b1, 1'b0, 1'b0); tick();
      for (int n = 1; n <= 5; n++) begin
         drive(1'b0, 1'b1, 1'b1); tick();
         drive(1'b0, 1'b1, 1'b0); tick();
         drive(1'b0, 1'b1, 1'b1); tick();
         drive(1'b0, 1'b1, 1'b1);
         chk("t5_match", match, 1);
         tick();
         chk($sformatf("t5_count8_n%0d", n), match_count, n);
         chk($sformatf("t5_count2_n%0d", n), match_count2, (n > 3) ? 3 : n);
      end

      // 6: clear beats the final matching bit
      drive(1'b0, 1'b1, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1); tick();
      chk("t6_state_pre", state, 3);
      drive(1'b1, 1'b1, 1'b1);
      chk("t6_clear_match", match, 0);
      tick();
      chk("t6_clear_state", state, 0);
      chk("t6_clear_count", match_count, 0);
      chk("t6_clear_count2", match_count2, 0);
      chk("t6_clear_match_q", match_q, 0);

      // Async reset mid-pattern, no clock edge needed
      drive(1'b0, 1'b1, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0); tick();
      chk("t6_state_mid", state, 2);
      rst = 1'b0;
      #1;
      chk("t6_async_state", state, 0);
      chk("t6_async_match", match, 0);
      drive(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      drive(1'b0, 1'b1, 1'b1);
      chk("t6_restart_match", match, 0);
      tick();
      chk("t6_restart_state", state, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
